// File: rtl/rmt_ingress_arbiter_pkg.sv
// Shared types and AXI-Stream widths for the ingress arbiter; widths match
// the slave stream of rmt_wrapper.
package rmt_arb_pkg;

  localparam int C_S_AXIS_DATA_WIDTH  = 512;
  localparam int C_S_AXIS_KEEP_WIDTH  = C_S_AXIS_DATA_WIDTH / 8;
  localparam int C_S_AXIS_TUSER_WIDTH = 128;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_CTRL = 2'd1,
    GNT_DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rmt_ingress_arbiter_if.sv
// AXI-Stream bundle used for both arbiter inputs and the merged output.
interface rmt_ingress_arbiter_if
  import rmt_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = C_S_AXIS_DATA_WIDTH,
  parameter int TUSER_WIDTH = C_S_AXIS_TUSER_WIDTH
) ();

  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [TUSER_WIDTH-1:0]  tuser;
  logic                    tvalid;
  logic                    tlast;
  logic                    tready;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);

endinterface

// File: rtl/rmt_ingress_arbiter.sv
// Packet-granular control/data stream merge in front of rmt_wrapper. Control
// wins in IDLE until CTRL_BURST_MAX packets have gone while data waited.
module rmt_ingress_arbiter
  import rmt_arb_pkg::*;
#(
  parameter int CTRL_BURST_MAX = 4,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  rmt_ingress_arbiter_if.slave  s_ctrl_axis,
  rmt_ingress_arbiter_if.slave  s_data_axis,
  rmt_ingress_arbiter_if.master m_axis,
  output logic [CNT_WIDTH-1:0] ctrl_pkt_cnt,
  output logic [CNT_WIDTH-1:0] data_pkt_cnt
);

  localparam int BW = $clog2(CTRL_BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(CTRL_BURST_MAX);

  arb_state_e           state_q, state_d;
  logic [BW-1:0]        burst_q, burst_d;
  logic [CNT_WIDTH-1:0] ctrl_cnt_q, ctrl_cnt_d;
  logic [CNT_WIDTH-1:0] data_cnt_q, data_cnt_d;
  logic                 ctrl_done, data_done;

  assign ctrl_done = (state_q == GNT_CTRL) && s_ctrl_axis.tvalid && m_axis.tready && s_ctrl_axis.tlast;
  assign data_done = (state_q == GNT_DATA) && s_data_axis.tvalid && m_axis.tready && s_data_axis.tlast;

  always_comb begin
    m_axis.tdata       = '0;
    m_axis.tkeep       = '0;
    m_axis.tuser       = '0;
    m_axis.tvalid      = 1'b0;
    m_axis.tlast       = 1'b0;
    s_ctrl_axis.tready = 1'b0;
    s_data_axis.tready = 1'b0;
    case (state_q)
      GNT_CTRL: begin
        m_axis.tdata       = s_ctrl_axis.tdata;
        m_axis.tkeep       = s_ctrl_axis.tkeep;
        m_axis.tuser       = s_ctrl_axis.tuser;
        m_axis.tvalid      = s_ctrl_axis.tvalid;
        m_axis.tlast       = s_ctrl_axis.tlast;
        s_ctrl_axis.tready = m_axis.tready;
      end
      GNT_DATA: begin
        m_axis.tdata       = s_data_axis.tdata;
        m_axis.tkeep       = s_data_axis.tkeep;
        m_axis.tuser       = s_data_axis.tuser;
        m_axis.tvalid      = s_data_axis.tvalid;
        m_axis.tlast       = s_data_axis.tlast;
        s_data_axis.tready = m_axis.tready;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    ctrl_cnt_d = ctrl_cnt_q;
    data_cnt_d = data_cnt_q;
    case (state_q)
      IDLE: begin
        if (s_ctrl_axis.tvalid && (!s_data_axis.tvalid || burst_q < BURST_MAX))
          state_d = GNT_CTRL;
        else if (s_data_axis.tvalid)
          state_d = GNT_DATA;
      end
      GNT_CTRL: if (ctrl_done) state_d = IDLE;
      GNT_DATA: if (data_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // Burst only accumulates while data is actually waiting behind control.
    if (ctrl_done) begin
      ctrl_cnt_d = ctrl_cnt_q + 1'b1;
      if (!s_data_axis.tvalid)
        burst_d = '0;
      else if (burst_q < BURST_MAX)
        burst_d = burst_q + BW'(1);
    end
    if (data_done) begin
      data_cnt_d = data_cnt_q + 1'b1;
      burst_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      burst_q    <= '0;
      ctrl_cnt_q <= '0;
      data_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      ctrl_cnt_q <= ctrl_cnt_d;
      data_cnt_q <= data_cnt_d;
    end
  end

  assign ctrl_pkt_cnt = ctrl_cnt_q;
  assign data_pkt_cnt = data_cnt_q;

endmodule

// File: doc/rmt_ingress_arbiter.md
# rmt_ingress_arbiter

Packet-granular two-input AXI-Stream arbiter that merges the reconfiguration (control) stream and the data stream into the single 512-bit slave stream of `rmt_wrapper`. Control packets have priority so table and page updates land quickly. A burst limit guarantees data forward progress. Beats of different packets are never interleaved.

## Interface
- `C_S_AXIS_DATA_WIDTH`, 512, tdata width; tkeep width is `/8`.
- `C_S_AXIS_TUSER_WIDTH`, 128, tuser width.
- `CTRL_BURST_MAX`, 4, maximum consecutive control packets granted while data is waiting (≥1).
- `CNT_WIDTH`, 32, width of the packet counters.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: reset, synchronous, active-high.
- `s_ctrl_axis_tdata/tkeep/tuser/tvalid/tlast` in: control input stream.
- `s_ctrl_axis_tready` out 1: ready for the control stream.
- `s_data_axis_tdata/tkeep/tuser/tvalid/tlast` in: data input stream.
- `s_data_axis_tready` out 1: ready for the data stream.
- `m_axis_tdata/tkeep/tuser/tvalid/tlast` out: merged stream to `rmt_wrapper`.
- `m_axis_tready` in 1: downstream ready.
- `ctrl_pkt_cnt` out CNT_WIDTH: control packets forwarded.
- `data_pkt_cnt` out CNT_WIDTH: data packets forwarded.

## Operation
- States:
  - IDLE: no grant.
  - GNT_CTRL: passthrough from the control input.
  - GNT_DATA: passthrough from the data input.
- IDLE decision, evaluated each cycle:
  - Control valid, and (data not valid or `burst_cnt < CTRL_BURST_MAX`) → GNT_CTRL.
  - Otherwise, data valid → GNT_DATA.
  - Neither valid → stay in IDLE.
- `burst_cnt`:
  - Increments when a control packet completes.
  - Clears when a data packet completes.
  - Also clears when a control packet completes while data is not valid; the count then restarts at 0.
  - Saturates at `CTRL_BURST_MAX`.
- GNT_x behaviour:
  - m_axis_* is a combinational mux of input x.
  - s_x_tready = m_axis_tready.
  - The other input's tready = 0.
- A packet completes on the beat where the granted tvalid, m_axis_tready and tlast are all 1. Next state is IDLE. The matching counter increments (wraps modulo 2^CNT_WIDTH).
- In IDLE, m_axis_tvalid = 0 and both s_*_tready = 0. tdata/tkeep/tuser/tlast are don't-care, driven 0.
- A grant is never revoked mid-packet, even if the granted tvalid deasserts (bubbles are passed through).
- tuser and tkeep pass through unmodified; there is no inspection of packet contents.

## Timing
- Decision costs one cycle: the first beat appears on m_axis in the cycle after IDLE samples tvalid.
- The minimum gap between packets is one idle cycle (the IDLE state).
- Mux path latency within a packet is 0 cycles (combinational), with no internal buffering.
- Reset:
  - State is IDLE, `burst_cnt` is 0, and both counters are 0.
  - All outputs are 0, including both treadys.
- Reset asserted mid-packet: the arbiter returns to IDLE on the next edge and the packet remainder is abandoned. Upstream and downstream must be reset together.
- Simultaneous valid in IDLE: priority follows the rule above, and the starved-data case always yields to data.
- Single-beat packets (tvalid and tlast on the first beat) complete in the first grant cycle.
- When `m_axis_tready` is held 0, the grant persists indefinitely and no counter changes.

## Structure
- Shared package `rmt_arb_pkg`:
  - state enum {IDLE, GNT_CTRL, GNT_DATA}.
  - AXIS width localparams (512/64/128), matching `rmt_wrapper`.
- No sub-module is required; the FSM, burst counter and packet counters stay in one file. Expected size is about 150 lines.
- Instantiated directly in front of `rmt_wrapper`. Its m_axis drives `rmt_wrapper` s_axis.

## Test plan
- Single control packet:
  - Stimulus: 2-beat control packet (tuser 0x40, second-beat tkeep 0x3), data idle.
  - Response: both beats appear on m_axis unmodified, starting one cycle after tvalid; `ctrl_pkt_cnt` = 1; `s_data_axis_tready` stays 0.
- Simultaneous request:
  - Stimulus: 2-beat control and 1-beat data packets presented in the same cycle.
  - Response: the control packet is forwarded first, then 1 idle cycle, then the data packet; counters read 1/1.
- Starvation bound:
  - Stimulus: control valid continuously with 6 back-to-back 3-beat packets, data valid throughout, `CTRL_BURST_MAX` = 4.
  - Response: order is C,C,C,C,D, then remaining C; `burst_cnt` clears after D.
- Backpressure:
  - Stimulus: `m_axis_tready` toggles 1,0,0,1 during a 3-beat data packet.
  - Response: no beat is lost or duplicated; `s_data_axis_tready` mirrors `m_axis_tready`; the grant holds until tlast.
- Input bubble:
  - Stimulus: the granted control input drops tvalid for 3 cycles mid-packet while data is valid.
  - Response: the data stream is not granted until the control tlast is accepted.
- Reset mid-packet:
  - Stimulus: `reset` is asserted on beat 1 of a 2-beat packet.
  - Response: the next cycle shows all outputs at 0 and both counters at 0; a new packet after reset is forwarded normally.
